// File: rtl/lcd_pkg.sv
// HD44780 controller shared definitions: command codes, FSM states,
// init ROM entry layout and DDRAM row base-address helper.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_ENTRY  = 8'h06;
  localparam logic [7:0] CMD_DISPON = 8'h0C;
  localparam logic [7:0] CMD_FSET8  = 8'h38;
  localparam logic [7:0] CMD_FSET4  = 8'h28;
  localparam logic [7:0] CMD_DDRAM  = 8'h80;
  localparam logic [7:0] CMD_WAKE   = 8'h30;
  localparam logic [7:0] CMD_WAKE4  = 8'h20;
  localparam logic [7:0] FSET_N     = 8'h08;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CLEAR
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD,
    PH_WAIT
  } tx_ph_t;

  typedef struct packed {
    logic [7:0]  code;
    logic        nib;
    logic [15:0] wait_us;
  } rom_ent_t;

  function automatic logic [6:0] row_base(
    input logic [1:0] row,
    input int         cols
  );
    logic [6:0] b;
    unique case (row)
      2'd0:    b = 7'h00;
      2'd1:    b = 7'h40;
      2'd2:    b = 7'(cols);
      default: b = 7'h40 + 7'(cols);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Character-write / clear request port of the LCD controller.
// master drives wr_valid/row/col/char and clr_req; slave returns wr_ready.
interface lcd_hd44780_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req;

  modport master (
    output wr_valid, wr_row, wr_col, wr_char, clr_req,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_char, clr_req,
    output wr_ready
  );
endinterface

// File: rtl/lcd_byte_tx.sv
// One byte (or single high nibble) strobe onto the LCD bus plus post-wait.
// start/rs/tx_byte/wait_cycles/nib4 in; done pulse and lcd_rs/en/data out.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int BUS4      = 0,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rs,
  input  logic [7:0]  tx_byte,
  input  logic [31:0] wait_cycles,
  input  logic        nib4,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_en,
  output logic [7:0]  lcd_data
);

  localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LD    = 32'(EN_CYC - 1);

  tx_ph_t      ph, ph_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] wait_r, wait_n;
  logic [7:0]  byte_r, byte_n;
  logic [7:0]  data_n;
  logic        lo, lo_n;
  logic        rs_n, en_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= PH_IDLE;
      cnt      <= '0;
      wait_r   <= '0;
      byte_r   <= '0;
      lo       <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= '0;
      done     <= 1'b0;
    end else begin
      ph       <= ph_n;
      cnt      <= cnt_n;
      wait_r   <= wait_n;
      byte_r   <= byte_n;
      lo       <= lo_n;
      lcd_rs   <= rs_n;
      lcd_en   <= en_n;
      lcd_data <= data_n;
      done     <= done_n;
    end
  end

  // The counter free-runs down to zero; each phase reloads it on exit.
  always_comb begin
    ph_n   = ph;
    cnt_n  = (cnt != '0) ? cnt - 32'd1 : cnt;
    wait_n = wait_r;
    byte_n = byte_r;
    lo_n   = lo;
    rs_n   = lcd_rs;
    en_n   = lcd_en;
    data_n = lcd_data;
    done_n = 1'b0;
    unique case (ph)
      PH_IDLE: begin
        if (start) begin
          ph_n   = PH_SETUP;
          cnt_n  = SETUP_LD;
          rs_n   = rs;
          byte_n = tx_byte;
          wait_n = wait_cycles;
          data_n = (BUS4 != 0) ? {tx_byte[7:4], 4'h0}
                               : tx_byte;
          lo_n   = (BUS4 != 0) && !nib4;
        end
      end
      PH_SETUP: begin
        if (cnt == '0) begin
          ph_n  = PH_EN;
          cnt_n = EN_LD;
          en_n  = 1'b1;
        end
      end
      PH_EN: begin
        if (cnt == '0) begin
          ph_n  = PH_HOLD;
          cnt_n = SETUP_LD;
          en_n  = 1'b0;
        end
      end
      PH_HOLD: begin
        if (cnt == '0) begin
          if (lo) begin
            // low nibble follows the hold with no extra wait
            ph_n   = PH_SETUP;
            cnt_n  = SETUP_LD;
            data_n = {byte_r[3:0], 4'h0};
            lo_n   = 1'b0;
          end else begin
            ph_n  = PH_WAIT;
            cnt_n = wait_r;
          end
        end
      end
      PH_WAIT: begin
        if (cnt == '0) begin
          ph_n   = PH_IDLE;
          done_n = 1'b1;
        end
      end
      default: ph_n = PH_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD controller: power-up init, cursor tracking,
// row/col character writes and clear over wr (slave), lcd_* bus out.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BUS4      = 0,
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int PWRUP_US  = 20000,
  parameter int CMD_US    = 40,
  parameter int CLR_US    = 1640,
  parameter int EN_CYC    = 12,
  parameter int SETUP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_hd44780_ctrl_if.slave  wr,
  output logic               init_done,
  output logic               busy,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic [7:0]         lcd_data
);

  localparam int          CYC_US = CLK_HZ / 1_000_000;
  localparam logic [31:0] PWR_LD = 32'(PWRUP_US * CYC_US - 1);
  localparam logic [15:0] CMD_W  = 16'(CMD_US);
  localparam logic [15:0] CLR_W  = 16'(CLR_US);
  localparam logic [2:0]  ROWS_L = 3'(ROWS);
  localparam logic [5:0]  COLS_L = 6'(COLS);
  localparam logic [2:0]  LAST   = 3'((BUS4 != 0) ? 7 : 6);
  localparam logic [7:0]  FSET   =
    ((BUS4 != 0) ? CMD_FSET4 : CMD_FSET8) &
    ~((ROWS == 1) ? FSET_N : 8'h00);

  function automatic logic [31:0] us2cyc(input logic [15:0] us);
    return 32'(us) * 32'(CYC_US) - 32'd1;
  endfunction

  // 8-bit mode skips entry 3 (the lone 0x2 nibble).
  function automatic rom_ent_t rom(input logic [2:0] i);
    logic [2:0] j;
    rom_ent_t   e;
    j = (BUS4 == 0 && i >= 3'd3) ? i + 3'd1 : i;
    unique case (j)
      3'd0:    e = {CMD_WAKE, 1'b1, 16'd4100};
      3'd1:    e = {CMD_WAKE, 1'b1, 16'd100};
      3'd2:    e = {CMD_WAKE, 1'b1, CMD_W};
      3'd3:    e = {CMD_WAKE4, 1'b1, CMD_W};
      3'd4:    e = {FSET, 1'b0, CMD_W};
      3'd5:    e = {CMD_DISPON, 1'b0, CMD_W};
      3'd6:    e = {CMD_CLEAR, 1'b0, CLR_W};
      default: e = {CMD_ENTRY, 1'b0, CMD_W};
    endcase
    return e;
  endfunction

  state_t      state, state_n;
  logic [31:0] pw_cnt;
  logic [2:0]  idx;
  logic        in_flight;
  logic        done_r;
  logic        cur_valid;
  logic [1:0]  cur_row;
  logic [4:0]  cur_col;
  logic [1:0]  rq_row;
  logic [4:0]  rq_col;
  logic [7:0]  rq_char;

  logic        ready;
  logic        wr_fire;
  logic        in_range;
  logic        addr_hit;
  logic [7:0]  ddram;
  rom_ent_t    ent;

  logic        tx_start;
  logic        tx_rs;
  logic [7:0]  tx_byte;
  logic [31:0] tx_wait;
  logic        tx_nib;
  logic        tx_done;

  assign ent      = rom(idx);
  assign in_range = ({1'b0, rq_row} < ROWS_L) &&
                    ({1'b0, rq_col} < COLS_L);
  assign addr_hit = cur_valid && cur_row == rq_row &&
                    cur_col == rq_col;
  assign ddram    = CMD_DDRAM |
                    {1'b0, row_base(rq_row, COLS) + 7'(rq_col)};
  assign wr_fire  = wr.wr_valid && ready;

  assign wr.wr_ready = ready;
  assign init_done   = done_r;
  assign busy        = state != ST_IDLE;
  assign lcd_rw      = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ready    = 1'b0;
    tx_start = 1'b0;
    tx_rs    = 1'b0;
    tx_byte  = 8'h00;
    tx_wait  = us2cyc(CMD_W);
    tx_nib   = 1'b0;
    unique case (state)
      ST_PWRUP: begin
        if (pw_cnt == '0) state_n = ST_INIT;
      end
      ST_INIT: begin
        tx_byte  = ent.code;
        tx_nib   = ent.nib;
        tx_wait  = us2cyc(ent.wait_us);
        tx_start = !in_flight;
        if (tx_done && idx == LAST) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        ready = done_r && !wr.clr_req;
        if (wr.clr_req)      state_n = ST_CLEAR;
        else if (wr_fire)    state_n = ST_ADDR;
      end
      ST_ADDR: begin
        // out-of-range writes cost one cycle and no bus traffic
        if (!in_range)       state_n = ST_IDLE;
        else if (addr_hit)   state_n = ST_DATA;
        else begin
          tx_byte  = ddram;
          tx_start = !in_flight;
          if (tx_done) state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_rs    = 1'b1;
        tx_byte  = rq_char;
        tx_start = !in_flight;
        if (tx_done) state_n = ST_IDLE;
      end
      ST_CLEAR: begin
        tx_byte  = CMD_CLEAR;
        tx_wait  = us2cyc(CLR_W);
        tx_start = !in_flight;
        if (tx_done) state_n = ST_IDLE;
      end
      default: state_n = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_cnt    <= PWR_LD;
      idx       <= '0;
      in_flight <= 1'b0;
      done_r    <= 1'b0;
      cur_valid <= 1'b0;
      cur_row   <= '0;
      cur_col   <= '0;
      rq_row    <= '0;
      rq_col    <= '0;
      rq_char   <= '0;
    end else begin
      if (state == ST_PWRUP && pw_cnt != '0)
        pw_cnt <= pw_cnt - 32'd1;
      if (tx_start)     in_flight <= 1'b1;
      else if (tx_done) in_flight <= 1'b0;
      if (state == ST_INIT && tx_done) begin
        idx <= idx + 3'd1;
        if (idx == LAST) begin
          done_r    <= 1'b1;
          cur_valid <= 1'b1;
          cur_row   <= '0;
          cur_col   <= '0;
        end
      end
      if (state == ST_IDLE && wr_fire) begin
        rq_row  <= wr.wr_row;
        rq_col  <= wr.wr_col;
        rq_char <= wr.wr_char;
      end
      if (state == ST_ADDR && tx_done) begin
        cur_valid <= 1'b1;
        cur_row   <= rq_row;
        cur_col   <= rq_col;
      end
      if (state == ST_DATA && tx_done) begin
        cur_col <= cur_col + 5'd1;
        // past the last column the panel address is not trusted
        if (6'(cur_col) + 6'd1 == COLS_L) cur_valid <= 1'b0;
      end
      if (state == ST_CLEAR && tx_done) begin
        cur_valid <= 1'b1;
        cur_row   <= '0;
        cur_col   <= '0;
      end
    end
  end

  lcd_byte_tx #(
    .BUS4      (BUS4),
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (tx_start),
    .rs          (tx_rs),
    .tx_byte     (tx_byte),
    .wait_cycles (tx_wait),
    .nib4        (tx_nib),
    .done        (tx_done),
    .lcd_rs      (lcd_rs),
    .lcd_en      (lcd_en),
    .lcd_data    (lcd_data)
  );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: 8-bit 2x16, 4-bit and 8-bit 4x20 instances
// with a per-instance expected-strobe queue checked on every lcd_en rise.
module tb_lcd_hd44780_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  lcd_hd44780_ctrl_if w8();
  lcd_hd44780_ctrl_if w4();
  lcd_hd44780_ctrl_if wr4();

  logic [2:0] en, rs, rw, idone, bsy;
  logic [7:0] dat [3];

  lcd_hd44780_ctrl #(
    .CLK_HZ(1_000_000), .BUS4(0), .ROWS(2), .COLS(16),
    .PWRUP_US(50), .CMD_US(4), .CLR_US(10),
    .EN_CYC(2), .SETUP_CYC(2)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .wr(w8),
    .init_done(idone[0]), .busy(bsy[0]),
    .lcd_rs(rs[0]), .lcd_rw(rw[0]),
    .lcd_en(en[0]), .lcd_data(dat[0])
  );

  lcd_hd44780_ctrl #(
    .CLK_HZ(1_000_000), .BUS4(1), .ROWS(2), .COLS(16),
    .PWRUP_US(50), .CMD_US(4), .CLR_US(10),
    .EN_CYC(2), .SETUP_CYC(2)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .wr(w4),
    .init_done(idone[1]), .busy(bsy[1]),
    .lcd_rs(rs[1]), .lcd_rw(rw[1]),
    .lcd_en(en[1]), .lcd_data(dat[1])
  );

  lcd_hd44780_ctrl #(
    .CLK_HZ(1_000_000), .BUS4(0), .ROWS(4), .COLS(20),
    .PWRUP_US(50), .CMD_US(4), .CLR_US(10),
    .EN_CYC(2), .SETUP_CYC(2)
  ) dutr (
    .clk(clk), .rst_n(rst_n), .wr(wr4),
    .init_done(idone[2]), .busy(bsy[2]),
    .lcd_rs(rs[2]), .lcd_rw(rw[2]),
    .lcd_en(en[2]), .lcd_data(dat[2])
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         min_gap;
  } exp_t;

  typedef struct {
    logic [1:0] row;
    logic [4:0] col;
    logic [7:0] ch;
    bit         drop;
    bit         has_addr;
    logic [7:0] addr;
  } vec_t;

  exp_t expq [3][$];
  vec_t tbl [7];
  int   errors = 0;
  int   checks = 0;
  bit   mon_on [3];
  int   hi [3];
  logic pen [3];
  int   last_fall [3];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi_v);
    checks++;
    if (act < lo || act > hi_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d",
               nm, act, lo, hi_v);
    end
  endtask

  task automatic push(input int k, input logic r,
                      input logic [7:0] d, input int g);
    exp_t e;
    e.rs = r;
    e.d = d;
    e.min_gap = g;
    expq[k].push_back(e);
  endtask

  task automatic push_init8(input int k);
    logic [7:0] s [7];
    s = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 7; i++) push(k, 1'b0, s[i], 0);
  endtask

  task automatic push_init4();
    logic [3:0] s [12];
    s = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
          4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    for (int i = 0; i < 12; i++) push(1, 1'b0, {s[i], 4'h0}, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        pen[k] = 1'b0;
        hi[k] = 0;
      end else begin
        if (en[k] && !pen[k]) begin
          hi[k] = 1;
          if (mon_on[k]) begin
            if (expq[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d spurious strobe: got %0h want none",
                       k, dat[k]);
            end else begin
              e = expq[k].pop_front();
              chk($sformatf("dut%0d_rs", k), 32'(rs[k]), 32'(e.rs));
              chk($sformatf("dut%0d_data", k), 32'(dat[k]), 32'(e.d));
              if (k == 0) chk("dut0_rw", 32'(rw[0]), 0);
              if (k == 1) chk("dut1_lownib", 32'(dat[1][3:0]), 0);
              if (e.min_gap > 0)
                chk_rng($sformatf("dut%0d_gap", k),
                        cyc - last_fall[k], e.min_gap, e.min_gap + 8);
            end
          end
        end else if (en[k]) begin
          hi[k]++;
        end
        if (!en[k] && pen[k]) begin
          if (mon_on[k]) chk($sformatf("dut%0d_en_width", k), hi[k], 2);
          last_fall[k] = cyc;
        end
        pen[k] = en[k];
      end
    end
  end

  task automatic hs8(input logic [1:0] r, input logic [4:0] c,
                     input logic [7:0] ch);
    int n;
    @(negedge clk);
    w8.wr_row = r;
    w8.wr_col = c;
    w8.wr_char = ch;
    w8.wr_valid = 1'b1;
    n = 0;
    while (!w8.wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_accept", 32'(w8.wr_ready), 1);
    @(posedge clk);
    #1 w8.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k, output bit rdy_hi);
    int n;
    rdy_hi = 1'b0;
    @(negedge clk);
    n = 1;
    while (bsy[k] && n < 500) begin
      if (k == 0 && w8.wr_ready) rdy_hi = 1'b1;
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_back_idle", k), 32'(bsy[k]), 0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit rdy_hi;
    vec_t v;

    tbl[0] = '{2'd1, 5'd5,  8'h41, 1'b0, 1'b1, 8'hC5};
    tbl[1] = '{2'd1, 5'd6,  8'h42, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{2'd2, 5'd0,  8'h58, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{2'd0, 5'd15, 8'h5A, 1'b0, 1'b1, 8'h8F};
    tbl[4] = '{2'd0, 5'd0,  8'h51, 1'b0, 1'b1, 8'h80};
    tbl[5] = '{2'd0, 5'd16, 8'h59, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{2'd0, 5'd1,  8'h71, 1'b0, 1'b0, 8'h00};

    w8.wr_valid = 0; w8.wr_row = 0; w8.wr_col = 0;
    w8.wr_char = 0; w8.clr_req = 0;
    w4.wr_valid = 0; w4.wr_row = 0; w4.wr_col = 0;
    w4.wr_char = 0; w4.clr_req = 0;
    wr4.wr_valid = 0; wr4.wr_row = 0; wr4.wr_col = 0;
    wr4.wr_char = 0; wr4.clr_req = 0;
    for (int k = 0; k < 3; k++) begin
      mon_on[k] = 1'b1;
      last_fall[k] = 0;
    end

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en[0]), 0);
    chk("rst_rs", 32'(rs[0]), 0);
    chk("rst_rw", 32'(rw[0]), 0);
    chk("rst_data", 32'(dat[0]), 0);
    chk("rst_ready", 32'(w8.wr_ready), 0);
    chk("rst_init_done", 32'(idone[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 1);

    push_init8(0);
    push_init4();
    push_init8(2);

    rst_n = 1'b1;
    n = 0;
    while (!en[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_rng("pwrup_quiet", n, 50, 60);

    n = 0;
    while (!idone[0] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done8", 32'(idone[0]), 1);
    chk_rng("init_done_after_wait", cyc - last_fall[0], 6, 12);
    chk("init8_all_sent", 32'(expq[0].size()), 0);
    chk("idle_ready", 32'(w8.wr_ready), 1);
    chk("idle_busy", 32'(bsy[0]), 0);

    n = 0;
    while (!(idone[1] && idone[2]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done4", 32'(idone[1]), 1);
    chk("init4_all_sent", 32'(expq[1].size()), 0);
    chk("init_doner", 32'(idone[2]), 1);
    chk("initr_all_sent", 32'(expq[2].size()), 0);

    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      if (!v.drop) begin
        if (v.has_addr) push(0, 1'b0, v.addr, 0);
        push(0, 1'b1, v.ch, 0);
      end
      hs8(v.row, v.col, v.ch);
      if (v.drop) begin
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("wr%0d_drop_ready", i), 32'(w8.wr_ready), 1);
        chk($sformatf("wr%0d_drop_busy", i), 32'(bsy[0]), 0);
      end else begin
        wait_idle(0, rdy_hi);
        chk($sformatf("wr%0d_ready_low", i), 32'(rdy_hi), 0);
      end
      chk($sformatf("wr%0d_queue", i), 32'(expq[0].size()), 0);
    end

    push(2, 1'b0, 8'h94, 0);
    push(2, 1'b1, 8'h52, 0);
    @(negedge clk);
    wr4.wr_row = 2'd2;
    wr4.wr_col = 5'd0;
    wr4.wr_char = 8'h52;
    wr4.wr_valid = 1'b1;
    n = 0;
    while (!wr4.wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("r4_accept", 32'(wr4.wr_ready), 1);
    @(posedge clk);
    #1 wr4.wr_valid = 1'b0;
    wait_idle(2, rdy_hi);
    chk("r4_queue", 32'(expq[2].size()), 0);

    push(0, 1'b0, 8'h01, 0);
    push(0, 1'b0, 8'hC2, 14);
    push(0, 1'b1, 8'h4B, 0);
    @(negedge clk);
    w8.wr_row = 2'd1;
    w8.wr_col = 5'd2;
    w8.wr_char = 8'h4B;
    w8.wr_valid = 1'b1;
    w8.clr_req = 1'b1;
    #1 chk("clr_ready_low", 32'(w8.wr_ready), 0);
    @(posedge clk);
    #1 w8.clr_req = 1'b0;
    n = 0;
    while (!w8.wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_then_accept", 32'(w8.wr_ready), 1);
    @(posedge clk);
    #1 w8.wr_valid = 1'b0;
    wait_idle(0, rdy_hi);
    chk("clr_queue", 32'(expq[0].size()), 0);

    mon_on[1] = 1'b0;
    mon_on[2] = 1'b0;
    push(0, 1'b0, 8'h83, 0);
    hs8(2'd0, 5'd3, 8'h4D);
    n = 0;
    while (!en[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("pre_rst_en_high", 32'(en[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(en[0]), 0);
    chk("async_rst_busy", 32'(bsy[0]), 1);
    chk("mid_rst_queue", 32'(expq[0].size()), 0);
    expq[0].delete();
    push_init8(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!en[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_rng("repwrup_quiet", n, 50, 60);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Parametrised HD44780/LCD1602-class character LCD controller and successor to the fixed lcd1602 block. It supports 8-bit or 4-bit bus mode, 1/2/4-row panels of any column count, and clock-frequency-derived timing. A valid/ready character-write port with row/col addressing and a clear request replaces the fixed message, so game logic can update the display at runtime. After reset it runs the full power-up init sequence autonomously.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; CYC_US = CLK_HZ/1_000_000
BUS4, 0, 1 = 4-bit mode on lcd_data[7:4]; 0 = 8-bit mode
ROWS, 2, panel rows: 1, 2 or 4
COLS, 16, panel columns: 8..20
PWRUP_US, 20000, power-up wait before the first command
CMD_US, 40, post-byte wait for normal commands and data
CLR_US, 1640, post-byte wait for clear (0x01)
EN_CYC, 12, lcd_en high width in clocks
SETUP_CYC, 2, RS/data setup before the lcd_en rise, and hold after its fall, in clocks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  character write request
wr_ready  out  1  controller accepts wr_* this cycle
wr_row  in  2  target row
wr_col  in  5  target column
wr_char  in  8  ASCII/CGROM code
clr_req  in  1  single-cycle clear-display request
init_done  out  1  init sequence finished (sticky until reset)
busy  out  1  any bus transfer or wait in progress
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_en  out  1  enable strobe
lcd_data  out  8  data bus; in 4-bit mode [3:0] = 0

Behaviour:
- Reset (async, rst_n = 0): lcd_rs = 0, lcd_rw = 0, lcd_en = 0, lcd_data = 0x00, wr_ready = 0, init_done = 0, busy = 1, cursor invalid. Deassertion mid-operation restarts from PWRUP.
- Timing: one free-running down-counter, loaded as N_US*CYC_US-1 or as a cycle count.
- Byte transfer, per nibble in 4-bit mode:
  - set RS and data;
  - SETUP_CYC clocks later, lcd_en = 1 for EN_CYC clocks;
  - lcd_en = 0, bus held SETUP_CYC clocks;
  - in 4-bit mode the high nibble goes first, then the low nibble with no extra wait between them;
  - then wait CMD_US, or CLR_US after 0x01.
- FSM states: PWRUP, INIT, IDLE, ADDR, DATA, CLEAR.
- PWRUP: wait PWRUP_US, then go to INIT.
- INIT sends this ROM list, each entry followed by its wait:
  - 0x30, 0x30, 0x30 as single nibble 0x3 in 4-bit mode, with 4100/100/CMD_US wait;
  - in 4-bit mode only, nibble 0x2;
  - function set: 0x38 (8-bit) / 0x28 (4-bit), with N = 0 when ROWS == 1;
  - 0x0C, 0x01 (CLR_US), 0x06.
  - After the last entry: init_done = 1, cursor = (0,0), go to IDLE.
- IDLE:
  - wr_ready = init_done & ~clr_req; busy = 0.
  - clr_req has priority; a write handshake happens only on wr_valid & wr_ready.
- Write accepted:
  - If wr_row >= ROWS or wr_col >= COLS, the write is dropped: zero bus activity, back to IDLE next cycle.
  - Otherwise, if the cursor is invalid or != (row,col), ADDR sends 0x80|addr, where addr = {0x00, 0x40, COLS, 0x40+COLS}[row] + col.
  - Then DATA sends wr_char with RS = 1.
  - The inputs are captured on the handshake; they need not be held.
- Cursor tracking: after data, col += 1. When col reaches COLS, the cursor becomes invalid; no auto-wrap is relied on.
- CLEAR: sends 0x01 with CLR_US wait, cursor = (0,0) valid.
- clr_req outside IDLE is ignored and not queued.
- busy = 1 in every non-IDLE state.

Decomposition:
- Package lcd_pkg holds:
  - command constants: CMD_CLEAR, CMD_ENTRY, CMD_DISPON, CMD_FSET8, CMD_FSET4, CMD_DDRAM;
  - the FSM state enum;
  - the row base-address function.
- Sub-module lcd_byte_tx performs one byte/nibble strobe plus post-wait (inputs start, rs, byte, wait_cycles, nib4; output done).
- The top level holds the init ROM, the cursor and the request FSM.

Test Plan:
Sim params for all cases: CLK_HZ = 1_000_000, PWRUP_US = 50, CMD_US = 4, CLR_US = 10, EN_CYC = 2.
- Power-up, 8-bit: release rst_n. Required:
  - no lcd_en pulse for 50 clocks;
  - command bytes 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06, each lcd_en high exactly 2 clocks, rs = 0, rw = 0;
  - init_done rises after the 0x06 wait.
- 4-bit mode (BUS4 = 1): required nibble sequence 3, 3, 3, 2, 2, 8, 0, C, 0, 1, 0, 6 on lcd_data[7:4], with lcd_data[3:0] = 0 throughout.
- Write 'A' at (1,5), then 'B' at (1,6). Required:
  - command 0x85|0x40 = 0xC5 with rs = 0, then data 0x41 with rs = 1;
  - for 'B', only data 0x42 (no address byte);
  - wr_ready low during both transfers.
- Write at (2,0) with ROWS = 2: handshake completes, no lcd_en edge, wr_ready back high in 2 cycles. With ROWS = 4, COLS = 20, (2,0) gives address byte 0x94.
- clr_req and wr_valid asserted in the same IDLE cycle: wr_ready = 0 that cycle, 0x01 is sent with a 10-clock wait, and the pending write is accepted afterwards with an address byte 0x80|addr.
- Reset asserted during an lcd_en-high pulse: lcd_en = 0 and busy = 1 immediately (async); after release the full PWRUP wait repeats.
